// File: rtl/dma_desc_ctrl_if.sv
// Descriptor-write, descriptor-fetch and engine-start bus of dma_desc_ctrl.
// master = descriptor controller, slave = CPU / fetch unit / DMA engine.
interface dma_desc_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [CH_W-1:0]   DESC_ch;
    logic [3:0]        DESC_sel;
    logic [DATA_W-1:0] DESC_input;
    logic              DESC_write_en;
    logic              DESC_commit;

    logic              fetch_req;
    logic [CH_W-1:0]   fetch_ch;
    logic [ADDR_W-1:0] fetch_addr;

    logic              eng_valid;
    logic              eng_ready;
    logic [CH_W-1:0]   eng_ch;
    logic [ADDR_W-1:0] eng_src;
    logic [ADDR_W-1:0] eng_dst;
    logic [DATA_W-1:0] eng_len;
    logic              eng_done;

    modport master (
        input  DESC_ch, DESC_sel, DESC_input, DESC_write_en, DESC_commit,
        output fetch_req, fetch_ch, fetch_addr,
        output eng_valid, eng_ch, eng_src, eng_dst, eng_len,
        input  eng_ready, eng_done
    );

    modport slave (
        output DESC_ch, DESC_sel, DESC_input, DESC_write_en, DESC_commit,
        input  fetch_req, fetch_ch, fetch_addr,
        input  eng_valid, eng_ch, eng_src, eng_dst, eng_len,
        output eng_ready, eng_done
    );
endinterface

// File: rtl/dma_desc_ctrl.sv
// Multi-channel DMA descriptor controller: per-channel descriptor store, round-robin launch
// onto a single engine, chain fetch requests and sticky end-of-chain interrupts.
// Optional: define DMA_DESC_ZLEN_SKIP_EN to retire LEN==0 descriptors without launching them.
module dma_desc_ctrl #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] DMAEN,
    dma_desc_ctrl_if.master   bus,
    input  logic [NUM_CH-1:0] irq_clr,
    output logic [NUM_CH-1:0] irq_pend,
    output logic              DMA_interrupt
);
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_LAUNCH, S_BUSY, S_FETCH} state_t;

    state_t                        state     [NUM_CH];
    state_t                        state_nxt [NUM_CH];
    logic [NUM_CH-1:0][ADDR_W-1:0] src, dst, nxt_desc;
    logic [NUM_CH-1:0][DATA_W-1:0] len;
    logic [NUM_CH-1:0]             eoc;
    logic [CH_W-1:0]               rr_ptr;
    logic                          eng_busy, grant, zskip;
    logic [CH_W-1:0]               grant_ch;
    logic [NUM_CH-1:0]             elig, irq_set;
    int                            idx;

    always_comb begin
        eng_busy = 1'b0;
        elig     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (state[i] == S_LAUNCH || state[i] == S_BUSY) eng_busy = 1'b1;
            elig[i] = (state[i] == S_ARMED) && DMAEN[i];
        end
    end

    // Single-issue engine: arbitrate only while no channel owns it.
    always_comb begin
        grant    = 1'b0;
        grant_ch = '0;
        idx      = 0;
        if (!eng_busy) begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                if (!grant && elig[idx]) begin
                    grant    = 1'b1;
                    grant_ch = CH_W'(idx);
                end
            end
        end
    end

`ifdef DMA_DESC_ZLEN_SKIP_EN
    assign zskip = grant && (len[grant_ch] == '0);
`else
    assign zskip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) state[i] <= S_IDLE;
        end else begin
            for (int i = 0; i < NUM_CH; i++) state[i] <= state_nxt[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_nxt[i] = state[i];
            case (state[i])
                S_IDLE:
                    if (bus.DESC_commit && int'(bus.DESC_ch) == i && DMAEN[i]) state_nxt[i] = S_ARMED;
                S_ARMED:
                    if (!DMAEN[i]) state_nxt[i] = S_IDLE;
                    else if (grant && grant_ch == CH_W'(i))
                        state_nxt[i] = zskip ? (eoc[i] ? S_IDLE : S_FETCH) : S_LAUNCH;
                S_LAUNCH:
                    if (bus.eng_ready) state_nxt[i] = S_BUSY;
                S_BUSY:
                    if (bus.eng_done) state_nxt[i] = (eoc[i] || !DMAEN[i]) ? S_IDLE : S_FETCH;
                S_FETCH:
                    if (!DMAEN[i]) state_nxt[i] = S_IDLE;
                    else if (bus.DESC_commit && int'(bus.DESC_ch) == i) state_nxt[i] = S_ARMED;
                default:
                    state_nxt[i] = S_IDLE;
            endcase
        end
    end

    // Descending scan so the lowest-index FETCH channel is presented.
    always_comb begin
        bus.fetch_req = 1'b0;
        bus.fetch_ch  = '0;
        irq_set       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (state[i] == S_FETCH) begin
                bus.fetch_req = 1'b1;
                bus.fetch_ch  = CH_W'(i);
            end
            irq_set[i] = eoc[i] && DMAEN[i] &&
                         ((state[i] == S_BUSY && bus.eng_done) || (zskip && grant_ch == CH_W'(i)));
        end
        bus.fetch_addr = nxt_desc[bus.fetch_ch];
        DMA_interrupt  = |irq_pend;
    end

    // Descriptor is locked from arm until the channel is back in IDLE or FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src      <= '0;
            dst      <= '0;
            len      <= '0;
            nxt_desc <= '0;
            eoc      <= '0;
        end else if (bus.DESC_write_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(bus.DESC_ch) == i && (state[i] == S_IDLE || state[i] == S_FETCH)) begin
                    case (bus.DESC_sel)
                        4'd0:    src[i]      <= bus.DESC_input[ADDR_W-1:0];
                        4'd1:    dst[i]      <= bus.DESC_input[ADDR_W-1:0];
                        4'd2:    len[i]      <= bus.DESC_input;
                        4'd3:    nxt_desc[i] <= bus.DESC_input[ADDR_W-1:0];
                        4'd4:    eoc[i]      <= bus.DESC_input[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.eng_valid <= 1'b0;
            bus.eng_ch    <= '0;
            bus.eng_src   <= '0;
            bus.eng_dst   <= '0;
            bus.eng_len   <= '0;
            rr_ptr        <= '0;
        end else begin
            if (bus.eng_valid && bus.eng_ready) bus.eng_valid <= 1'b0;
            if (grant) begin
                rr_ptr <= (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + 1'b1;
                if (!zskip) begin
                    bus.eng_valid <= 1'b1;
                    bus.eng_ch    <= grant_ch;
                    bus.eng_src   <= src[grant_ch];
                    bus.eng_dst   <= dst[grant_ch];
                    bus.eng_len   <= len[grant_ch];
                end
            end
        end
    end

    // A new end-of-chain event beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_pend <= '0;
        else        irq_pend <= (irq_pend & ~irq_clr) | irq_set;
    end
endmodule
